// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle RISC-V core: sequences fetch/decode/execute/memory/writeback.
// Latency: Moore outputs from the state register; only FETCH enables and ImmSrc follow inputs combinationally.
// Backpressure: MemReady=0 holds FETCH, MEMREAD and MEMWRITE one cycle per low cycle; ignored elsewhere.
//
// Ports:
//   clk, reset (sync, active-high)   op (instr[6:0])   MemReady (memory access completes)
//   PCUpdate, Branch, RegWrite, MemWrite, IRWrite   datapath enables
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc   datapath mux selects
//   Illegal (trap)   State (debug view of the current state)
module multicycle_control_fsm #(
    parameter bit EN_JALR  = 1'b1,
    parameter bit EN_AUIPC = 1'b1,
    parameter bit EN_LUI   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       MemReady,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_JALR     = 4'd13,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_t r_state;
    state_t w_next;

    // Opcode classes; optional groups are folded in here so a disabled
    // opcode looks exactly like an unknown one everywhere downstream.
    logic w_is_lw, w_is_sw, w_is_r, w_is_ialu, w_is_beq, w_is_jal;
    logic w_is_lui, w_is_auipc, w_is_jalr;

    assign w_is_lw    = (op == OP_LW);
    assign w_is_sw    = (op == OP_SW);
    assign w_is_r     = (op == OP_R);
    assign w_is_ialu  = (op == OP_IALU);
    assign w_is_beq   = (op == OP_BEQ);
    assign w_is_jal   = (op == OP_JAL);
    assign w_is_lui   = EN_LUI   && (op == OP_LUI);
    assign w_is_auipc = EN_AUIPC && (op == OP_AUIPC);
    assign w_is_jalr  = EN_JALR  && (op == OP_JALR);

    // Raw enables before reset gating
    logic w_pcupdate, w_branch, w_regwrite, w_memwrite, w_irwrite, w_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pcupdate = 1'b0;
        w_branch   = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_illegal  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;

        case (r_state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                // IR load and PC+4 only commit on the cycle the fetch completes
                w_irwrite  = MemReady;
                w_pcupdate = MemReady;
                if (MemReady) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (w_is_lw || w_is_sw) w_next = S_MEMADR;
                else if (w_is_r)        w_next = S_EXECUTER;
                else if (w_is_ialu)     w_next = S_EXECUTEI;
                else if (w_is_beq)      w_next = S_BEQ;
                else if (w_is_jal)      w_next = S_JAL;
                else if (w_is_lui)      w_next = S_LUI;
                else if (w_is_auipc)    w_next = S_AUIPC;
                else if (w_is_jalr)     w_next = S_JALR;
                else                    w_next = S_ILLEGAL;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                // IR is frozen, so only lw/sw can be here; anything else traps
                if (w_is_lw)      w_next = S_MEMREAD;
                else if (w_is_sw) w_next = S_MEMWRITE;
                else              w_next = S_ILLEGAL;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                if (MemReady) w_next = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                w_branch = 1'b1;
                w_next   = S_FETCH;
            end
            S_JAL: begin
                // PC <= ALUOut (target) while ALU forms OldPC+4 for the link
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_JALR: begin
                // Target rs1+imm lands in ALUOut, then the JAL path finishes
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = S_JAL;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                w_next  = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                w_next  = S_ALUWB;
            end
            S_ILLEGAL: begin
                w_illegal = 1'b1;
                w_next    = S_ILLEGAL;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset masks every side effect in the same cycle it is asserted
    assign PCUpdate = w_pcupdate & ~reset;
    assign Branch   = w_branch   & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign IRWrite  = w_irwrite  & ~reset;
    assign Illegal  = w_illegal  & ~reset;
    assign State    = r_state;

    always_comb begin
        ImmSrc = 3'b000;
        if (w_is_lw || w_is_ialu || w_is_jalr) ImmSrc = 3'b000;
        else if (w_is_sw)                      ImmSrc = 3'b001;
        else if (w_is_beq)                     ImmSrc = 3'b010;
        else if (w_is_jal)                     ImmSrc = 3'b011;
        else if (w_is_lui || w_is_auipc)       ImmSrc = 3'b100;
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with a queue-based scoreboard.
// Latency: one expected record per cycle, checked at the falling edge of that cycle.
// Backpressure: MemReady is driven low in FETCH and MEMWRITE to stretch states.
module tb_multicycle_control_fsm;

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RT    = 7'b0110011;
    localparam logic [6:0] IA    = 7'b0010011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] BAD   = 7'b0000000;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       MemReady;

    logic       a_pcu, a_br, a_rw, a_mw, a_irw, a_adr, a_ill;
    logic [1:0] a_res, a_sa, a_sb, a_aop;
    logic [2:0] a_imm;
    logic [3:0] a_st;

    logic       b_pcu, b_br, b_rw, b_mw, b_irw, b_adr, b_ill;
    logic [1:0] b_res, b_sa, b_sb, b_aop;
    logic [2:0] b_imm;
    logic [3:0] b_st;

    multicycle_control_fsm u_dut (
        .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
        .PCUpdate(a_pcu), .Branch(a_br), .RegWrite(a_rw), .MemWrite(a_mw),
        .IRWrite(a_irw), .AdrSrc(a_adr), .ResultSrc(a_res), .ALUSrcA(a_sa),
        .ALUSrcB(a_sb), .ALUOp(a_aop), .ImmSrc(a_imm), .Illegal(a_ill), .State(a_st)
    );

    multicycle_control_fsm #(.EN_JALR(1'b1), .EN_AUIPC(1'b0), .EN_LUI(1'b1)) u_dut_na (
        .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
        .PCUpdate(b_pcu), .Branch(b_br), .RegWrite(b_rw), .MemWrite(b_mw),
        .IRWrite(b_irw), .AdrSrc(b_adr), .ResultSrc(b_res), .ALUSrcA(b_sa),
        .ALUSrcB(b_sb), .ALUOp(b_aop), .ImmSrc(b_imm), .Illegal(b_ill), .State(b_st)
    );

    typedef struct packed {
        logic       sel;
        logic [3:0] st;
        logic       pcu, br, rw, mw, irw, adr;
        logic [1:0] res, sa, sb, aop;
        logic [2:0] imm;
        logic       ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a given state, written from the state table
    function automatic exp_t mk(input logic s, input logic [3:0] st, input logic mr,
                                input logic rst, input logic [2:0] imm);
        exp_t e;
        e     = '0;
        e.sel = s;
        e.st  = st;
        e.imm = imm;
        case (st)
            4'd0:  begin e.sb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcu = mr; end
            4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            4'd3:  begin e.adr = 1'b1; end
            4'd4:  begin e.res = 2'b01; e.rw = 1'b1; end
            4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            4'd6:  begin e.sa = 2'b10; e.aop = 2'b10; end
            4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
            4'd8:  begin e.rw = 1'b1; end
            4'd9:  begin e.sa = 2'b10; e.aop = 2'b01; e.br = 1'b1; end
            4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcu = 1'b1; end
            4'd11: begin e.sa = 2'b11; e.sb = 2'b01; end
            4'd12: begin e.sa = 2'b01; e.sb = 2'b01; end
            4'd13: begin e.sa = 2'b10; e.sb = 2'b01; end
            4'd15: begin e.ill = 1'b1; end
            default: ;
        endcase
        if (rst) begin
            e.pcu = 1'b0; e.irw = 1'b0; e.rw = 1'b0;
            e.mw  = 1'b0; e.br  = 1'b0; e.ill = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle of inputs and queue what the selected DUT must show
    task automatic cyc(input logic s, input logic [6:0] o, input logic mr,
                       input logic rst, input logic [3:0] st, input logic [2:0] imm);
        op       = o;
        MemReady = mr;
        reset    = rst;
        q.push_back(mk(s, st, mr, rst, imm));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected record per cycle and compares at the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            a = '0;
            a.sel = e.sel;
            if (e.sel == 1'b0) begin
                a.st = a_st; a.pcu = a_pcu; a.br = a_br; a.rw = a_rw; a.mw = a_mw;
                a.irw = a_irw; a.adr = a_adr; a.res = a_res; a.sa = a_sa; a.sb = a_sb;
                a.aop = a_aop; a.imm = a_imm; a.ill = a_ill;
            end else begin
                a.st = b_st; a.pcu = b_pcu; a.br = b_br; a.rw = b_rw; a.mw = b_mw;
                a.irw = b_irw; a.adr = b_adr; a.res = b_res; a.sa = b_sa; a.sb = b_sb;
                a.aop = b_aop; a.imm = b_imm; a.ill = b_ill;
            end
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL ctl_cycle%0d dut%0d state got %0d want %0d, outputs got %h want %h",
                         cyc_n, e.sel, a.st, e.st, a, e);
            end
            cyc_n++;
        end
    end

    initial begin
        reset    = 1'b1;
        op       = LW;
        MemReady = 1'b1;
        @(posedge clk);
        #1;

        // Reset held: FETCH with every enable masked
        cyc(0, LW, 1, 1, 4'd0, 3'b000);

        // lw: 0,1,2,3,4
        cyc(0, LW, 1, 0, 4'd0, 3'b000);
        cyc(0, LW, 1, 0, 4'd1, 3'b000);
        cyc(0, LW, 1, 0, 4'd2, 3'b000);
        cyc(0, LW, 1, 0, 4'd3, 3'b000);
        cyc(0, LW, 1, 0, 4'd4, 3'b000);

        // sw with three wait cycles in MEMWRITE: four write-strobe cycles
        cyc(0, SW, 1, 0, 4'd0, 3'b001);
        cyc(0, SW, 1, 0, 4'd1, 3'b001);
        cyc(0, SW, 1, 0, 4'd2, 3'b001);
        cyc(0, SW, 0, 0, 4'd5, 3'b001);
        cyc(0, SW, 0, 0, 4'd5, 3'b001);
        cyc(0, SW, 0, 0, 4'd5, 3'b001);
        cyc(0, SW, 1, 0, 4'd5, 3'b001);

        // jalr: 0,1,13,10,8
        cyc(0, JALR, 1, 0, 4'd0, 3'b000);
        cyc(0, JALR, 1, 0, 4'd1, 3'b000);
        cyc(0, JALR, 1, 0, 4'd13, 3'b000);
        cyc(0, JALR, 1, 0, 4'd10, 3'b000);
        cyc(0, JALR, 1, 0, 4'd8, 3'b000);

        // beq with fetch stalled two cycles, then lui likewise
        cyc(0, BEQ, 0, 0, 4'd0, 3'b010);
        cyc(0, BEQ, 0, 0, 4'd0, 3'b010);
        cyc(0, BEQ, 1, 0, 4'd0, 3'b010);
        cyc(0, BEQ, 1, 0, 4'd1, 3'b010);
        cyc(0, BEQ, 1, 0, 4'd9, 3'b010);
        cyc(0, LUI, 0, 0, 4'd0, 3'b100);
        cyc(0, LUI, 0, 0, 4'd0, 3'b100);
        cyc(0, LUI, 1, 0, 4'd0, 3'b100);
        cyc(0, LUI, 1, 0, 4'd1, 3'b100);
        cyc(0, LUI, 1, 0, 4'd11, 3'b100);
        cyc(0, LUI, 1, 0, 4'd8, 3'b100);

        // Reset while stalled in MEMWRITE: strobe masked, then no more strobes
        cyc(0, SW, 1, 0, 4'd0, 3'b001);
        cyc(0, SW, 1, 0, 4'd1, 3'b001);
        cyc(0, SW, 1, 0, 4'd2, 3'b001);
        cyc(0, SW, 0, 0, 4'd5, 3'b001);
        cyc(0, SW, 0, 1, 4'd5, 3'b001);
        cyc(0, SW, 0, 0, 4'd0, 3'b001);
        cyc(0, SW, 0, 0, 4'd0, 3'b001);

        // jal, R-type, I-ALU, auipc
        cyc(0, JAL, 1, 0, 4'd0, 3'b011);
        cyc(0, JAL, 1, 0, 4'd1, 3'b011);
        cyc(0, JAL, 1, 0, 4'd10, 3'b011);
        cyc(0, JAL, 1, 0, 4'd8, 3'b011);
        cyc(0, RT, 1, 0, 4'd0, 3'b000);
        cyc(0, RT, 1, 0, 4'd1, 3'b000);
        cyc(0, RT, 1, 0, 4'd6, 3'b000);
        cyc(0, RT, 1, 0, 4'd8, 3'b000);
        cyc(0, IA, 1, 0, 4'd0, 3'b000);
        cyc(0, IA, 1, 0, 4'd1, 3'b000);
        cyc(0, IA, 1, 0, 4'd7, 3'b000);
        cyc(0, IA, 1, 0, 4'd8, 3'b000);
        cyc(0, AUIPC, 1, 0, 4'd0, 3'b100);
        cyc(0, AUIPC, 1, 0, 4'd1, 3'b100);
        cyc(0, AUIPC, 1, 0, 4'd12, 3'b100);
        cyc(0, AUIPC, 1, 0, 4'd8, 3'b100);

        // Unknown opcode traps; reset clears the trap
        cyc(0, BAD, 1, 0, 4'd0, 3'b000);
        cyc(0, BAD, 1, 0, 4'd1, 3'b000);
        cyc(0, BAD, 1, 0, 4'd15, 3'b000);
        cyc(0, BAD, 0, 0, 4'd15, 3'b000);
        cyc(0, BAD, 1, 1, 4'd15, 3'b000);

        // auipc disabled: DECODE goes to ILLEGAL and stays, ImmSrc 000
        cyc(1, AUIPC, 1, 0, 4'd0, 3'b000);
        cyc(1, AUIPC, 1, 0, 4'd1, 3'b000);
        for (int i = 0; i < 11; i++) begin
            cyc(1, AUIPC, i[0], 0, 4'd15, 3'b000);
        end
        cyc(1, AUIPC, 1, 1, 4'd15, 3'b000);
        cyc(1, AUIPC, 1, 0, 4'd0, 3'b000);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multi-cycle RISC-V core: sequences every instruction through fetch, decode, execute, memory and writeback, and drives all datapath enables and mux selects, including ImmSrc. It extends the combinational ImmSrc-only decoder with per-state control, optional opcode groups, a memory wait handshake and an illegal-instruction trap. It sits in the controller beside the ALU decoder, which consumes ALUOp.

## Interface
- EN_JALR, default 1: jalr (1100111) supported; 0 makes it illegal.
- EN_AUIPC, default 1: auipc (0010111) supported; 0 makes it illegal.
- EN_LUI, default 1: lui (0110111) supported; 0 makes it illegal.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- op  input  opcodetype (7)  instruction[6:0] from the instruction register.
- MemReady  input  1  memory completes the current access this cycle.
- PCUpdate  output  1  PC write enable (unconditional).
- Branch  output  1  PC write if ALU Zero.
- RegWrite  output  1  register file write enable.
- MemWrite  output  1  data memory write strobe.
- IRWrite  output  1  instruction register / OldPC write enable.
- AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address.
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  output  2  00 rs2, 01 ImmExt, 10 constant 4.
- ALUOp  output  2  00 add, 01 subtract, 10 funct-decoded.
- ImmSrc  output  3  immsrc.vh encodings: I 000, S 001, B 010, J 011, U 100.
- Illegal  output  1  trap indicator.
- State  output  4  current state, debug/verification only.

## Operation
- States and State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, LUI 11, AUIPC 12, JALR 13, ILLEGAL 15. Code 14 is unused and returns to FETCH.
- Outputs are Moore (state only), except FETCH enables, which are gated by MemReady. Signals not listed below are 0; ResultSrc, ALUSrcA, ALUSrcB and ALUOp default to 00.
- FETCH: AdrSrc 0, ALUSrcB 10, ResultSrc 10. IRWrite = PCUpdate = MemReady. Holds until MemReady, then goes to DECODE.
- DECODE: ALUSrcA 01, ALUSrcB 01 (computes the branch/jal target). Next state by op:
  - lw, sw → MEMADR.
  - R-type → EXECUTER.
  - I-ALU → EXECUTEI.
  - beq → BEQ.
  - jal → JAL.
  - lui → LUI.
  - auipc → AUIPC.
  - jalr → JALR.
  - any other op, or an opcode whose EN_* is 0 → ILLEGAL.
- MEMADR: ALUSrcA 10, ALUSrcB 01. lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: AdrSrc 1. Holds until MemReady, then → MEMWB.
- MEMWB: ResultSrc 01, RegWrite 1 → FETCH.
- MEMWRITE: AdrSrc 1, MemWrite 1 for every cycle held. Holds until MemReady, then → FETCH.
- EXECUTER: ALUSrcA 10, ALUOp 10 → ALUWB.
- EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10 → ALUWB.
- ALUWB: RegWrite 1 → FETCH.
- BEQ: ALUSrcA 10, ALUOp 01, Branch 1 → FETCH.
- JAL: ALUSrcA 01, ALUSrcB 10, PCUpdate 1 → ALUWB.
- JALR: ALUSrcA 10, ALUSrcB 01 → JAL, which reuses the JAL path with ALUOut = rs1+imm.
- LUI: ALUSrcA 11, ALUSrcB 01 → ALUWB.
- AUIPC: ALUSrcA 01, ALUSrcB 01 → ALUWB.
- ILLEGAL: Illegal 1 and all enables 0. Stays in ILLEGAL until reset.
- ImmSrc is combinational from op in every state:
  - lw, I-ALU, jalr → I.
  - sw → S.
  - beq → B.
  - jal → J.
  - lui, auipc → U.
  - otherwise 000.
  - Disabled opcodes also give 000.

## Timing
- Reset sampled at a clk edge sets State to FETCH. While reset is high, every enable (PCUpdate, IRWrite, RegWrite, MemWrite, Branch) is forced to 0, and Illegal is 0.
- Reset mid-instruction or in ILLEGAL aborts immediately; no partial writeback follows.
- Cycle counts with MemReady constantly 1:
  - lw 5.
  - sw 4.
  - R, I-ALU, lui, auipc 4.
  - beq 3.
  - jal 4.
  - jalr 5.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. MemReady is ignored in all other states.
- op is only sampled in DECODE and MEMADR. IR is stable there because IRWrite is 0 outside FETCH.

## Test plan
- Reset pulse in MEMWRITE with MemReady=0 → next cycle State=0, MemWrite=0, no further write strobes.
- lw (op 0000011), MemReady=1 → States 0,1,2,3,4,0; RegWrite=1 only in state 4; ImmSrc=000 throughout.
- sw with MemReady low for 3 cycles in MEMWRITE → MemWrite=1 for 4 cycles, then FETCH; ImmSrc=001.
- jalr (1100111) → States 0,1,13,10,8,0; PCUpdate=1 in FETCH and JAL; RegWrite=1 in ALUWB.
- EN_AUIPC=0, op 0010111 → DECODE→ILLEGAL, Illegal=1 held 10+ cycles, ImmSrc=000; reset → FETCH.
- beq then lui with MemReady=0 for 2 cycles in FETCH → IRWrite=PCUpdate=0 until MemReady=1; beq asserts Branch, ALUOp=01; lui asserts ALUSrcA=11, ImmSrc=100.
